prog_loader: RTL

Upstream boot stage for the single-cycle core: receives a program image as a byte stream and writes it, word by word, into the instruction/data memory write port. It holds the core in reset until a complete image with a valid checksum has been written, then releases it. It sits between the host byte link (UART receiver or testbench) and the core top's `rst` input and memory write port.

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/word_assembler.sv | 30 +++
 rtl/prog_loader.sv | 117 +++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and frame constants for the boot-image loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

    localparam logic [7:0] DEFAULT_MAGIC  = 8'hA5;
    localparam logic [7:0] CSUM_INIT      = 8'h00;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_assembler.sv
// Packs big-endian bytes into a 32-bit word; pulses word_full the cycle after the last byte lands.
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  data_in,
    output logic [31:0] word,
    output logic [1:0]  idx,
    output logic        word_full
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word      <= '0;
            idx       <= '0;
            word_full <= 1'b0;
        end else begin
            word_full <= shift && (idx == 2'(BYTES_PER_WORD - 1));
            if (shift) begin
                word <= {word[23:0], data_in};
                idx  <= idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses a MAGIC/length/data/checksum byte frame, writes words to memory,
// and holds the core in reset until a fully verified image has been written.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [7:0]  MAGIC     = DEFAULT_MAGIC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_rst,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    loader_state_t state, state_next;

    logic [7:0]  csum;
    logic [7:0]  len_hi;
    logic [15:0] n_words;
    logic [15:0] len_n;
    logic [31:0] word;
    logic [1:0]  idx;
    logic        accept;
    logic        start;
    logic        shift;
    logic        last_byte;
    logic        last_word;

    assign accept    = rx_valid && rx_ready;
    assign start     = accept && (rx_data == MAGIC) && (state == IDLE || state == ERROR);
    assign shift     = accept && (state == DATA);
    assign last_byte = shift && (idx == 2'(BYTES_PER_WORD - 1));
    assign last_word = last_byte && (words_loaded + 16'd1 == n_words);
    assign len_n     = {len_hi, rx_data};
    assign mem_wdata = word;

    word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (start),
        .shift     (shift),
        .data_in   (rx_data),
        .word      (word),
        .idx       (idx),
        .word_full (mem_we)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (start) state_next = LEN_HI;
            LEN_HI: if (accept) state_next = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if ({1'b0, len_n} > MAX_LEN) state_next = ERROR;
                    else if (len_n == 16'd0)     state_next = CSUM;
                    else                         state_next = DATA;
                end
            end
            DATA:   if (last_word) state_next = CSUM;
            CSUM:   if (accept) state_next = (rx_data == csum) ? DONE : ERROR;
            DONE:   state_next = DONE;
            ERROR:  if (start) state_next = LEN_HI;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ready     <= 1'b0;
            mem_addr     <= ADDR_BASE;
            core_rst     <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            csum         <= CSUM_INIT;
            len_hi       <= '0;
            n_words      <= '0;
        end else begin
            rx_ready   <= 1'b1;
            // Status flags follow the state being entered, so they appear one cycle after the deciding byte.
            core_rst   <= (state_next != DONE);
            load_done  <= (state_next == DONE);
            load_error <= (state_next == ERROR);
            if (start) begin
                csum         <= CSUM_INIT;
                words_loaded <= '0;
                mem_addr     <= ADDR_BASE;
            end else begin
                if (mem_we) mem_addr <= mem_addr + 32'd4;
                if (accept && (state == LEN_HI || state == LEN_LO || state == DATA))
                    csum <= csum ^ rx_data;
                if (accept && state == LEN_HI) len_hi  <= rx_data;
                if (accept && state == LEN_LO) n_words <= len_n;
                if (last_byte) words_loaded <= words_loaded + 16'd1;
            end
        end
    end

endmodule
